// File: rtl/uart_types_pkg.sv
// Shared UART types: LCR layout, receive FSM states and the pushed RX word.
`timescale 1ns/1ps
package uart_types_pkg;

    typedef struct packed {
        logic       dlab;
        logic       set_break;
        logic       stick_parity;
        logic       eps;
        logic       pen;
        logic       stb;
        logic [1:0] wls;
    } lcr_t;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRK_WAIT} rx_state_e;

    typedef struct packed {
        logic       bi;
        logic       fe;
        logic       pe;
        logic [7:0] data;
    } rx_word_t;

    localparam int UART_MIN_BITS = 5;

    // Parity bit the transmitter should have sent for this word.
    function automatic logic parity_expected(input logic stick, input logic eps,
                                             input logic [7:0] data);
        if (stick)
            return ~eps;
        return eps ? ^data : ~^data;
    endfunction

endpackage

// File: rtl/uart_sync.sv
// N-flop synchronizer with selectable reset value; 1-bit, latency STAGES clk.
// No backpressure.
`timescale 1ns/1ps
module uart_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (rst)
            sync_q <= {STAGES{RST_VAL}};
        else
            sync_q <= {sync_q[STAGES-2:0], d_i};
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// 16x-oversampled UART receiver: one word per frame, pushed at mid-stop-bit.
// Latency SYNC_STAGES clk + (1+nbits+pen)*OS + OS/2 ticks; no backpressure.
`timescale 1ns/1ps
module uart_rx
    import uart_types_pkg::*;
#(
    parameter int OVERSAMPLE  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       baud_tick_16x,
    input  logic       rx_i,
    input  logic       rx_en,
    input  lcr_t       lcr,
    output logic [7:0] rx_data,
    output logic       rx_pe,
    output logic       rx_fe,
    output logic       rx_bi,
    output logic       rx_valid,
    output logic       rx_busy
);

    localparam int             TW      = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0]  HALF_M1 = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0]  FULL_M1 = TW'(OVERSAMPLE - 1);

    rx_state_e     state_q;
    logic [TW-1:0] tick_q;
    logic [2:0]    bit_q;
    logic [2:0]    last_bit_q;
    logic          pen_q, eps_q, stick_q;
    logic [7:0]    shreg_q;
    logic          par_q;
    rx_word_t      word_q;
    logic          valid_q;
    logic          rx_s;
    logic          pe_d, bi_d;
    logic          lcr_unused;

    uart_sync #(
        .STAGES  (SYNC_STAGES),
        .RST_VAL (1'b1)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (rx_i),
        .q_o (rx_s)
    );

    assign lcr_unused = ^{lcr.stb, lcr.set_break, lcr.dlab};

    // Status for the word being closed out, evaluated with the stop-bit sample.
    assign pe_d = pen_q & (par_q != parity_expected(stick_q, eps_q, shreg_q));
    assign bi_d = (shreg_q == 8'h00) & (~pen_q | ~par_q) & ~rx_s;

    always_ff @(posedge clk) begin
        valid_q <= 1'b0;
        if (rst) begin
            state_q    <= IDLE;
            tick_q     <= '0;
            bit_q      <= '0;
            last_bit_q <= '0;
            pen_q      <= 1'b0;
            eps_q      <= 1'b0;
            stick_q    <= 1'b0;
            shreg_q    <= '0;
            par_q      <= 1'b0;
            word_q     <= '0;
        end else if (!rx_en) begin
            state_q <= IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
        end else if (baud_tick_16x) begin
            case (state_q)
                IDLE: begin
                    if (!rx_s) begin
                        state_q    <= START;
                        tick_q     <= '0;
                        bit_q      <= '0;
                        shreg_q    <= '0;
                        last_bit_q <= 3'(UART_MIN_BITS - 1) + {1'b0, lcr.wls};
                        pen_q      <= lcr.pen;
                        eps_q      <= lcr.eps;
                        stick_q    <= lcr.stick_parity;
                    end
                end
                START: begin
                    if (tick_q == HALF_M1) begin
                        tick_q  <= '0;
                        state_q <= rx_s ? IDLE : DATA;
                    end else begin
                        tick_q <= tick_q + TW'(1);
                    end
                end
                DATA: begin
                    if (tick_q == FULL_M1) begin
                        tick_q         <= '0;
                        shreg_q[bit_q] <= rx_s;
                        if (bit_q == last_bit_q)
                            state_q <= pen_q ? PARITY : STOP;
                        else
                            bit_q <= bit_q + 3'd1;
                    end else begin
                        tick_q <= tick_q + TW'(1);
                    end
                end
                PARITY: begin
                    if (tick_q == FULL_M1) begin
                        tick_q  <= '0;
                        par_q   <= rx_s;
                        state_q <= STOP;
                    end else begin
                        tick_q <= tick_q + TW'(1);
                    end
                end
                STOP: begin
                    // Leave at mid-stop so a back-to-back start edge is not missed.
                    if (tick_q == FULL_M1) begin
                        tick_q  <= '0;
                        word_q  <= '{bi: bi_d, fe: ~rx_s, pe: pe_d, data: shreg_q};
                        valid_q <= 1'b1;
                        state_q <= bi_d ? BRK_WAIT : IDLE;
                    end else begin
                        tick_q <= tick_q + TW'(1);
                    end
                end
                BRK_WAIT: begin
                    if (rx_s)
                        state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rx_data  = word_q.data;
    assign rx_pe    = word_q.pe;
    assign rx_fe    = word_q.fe;
    assign rx_bi    = word_q.bi;
    assign rx_valid = valid_q;
    assign rx_busy  = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: serial frames from a line-level model, words checked
// against a frame-level reference queue every clock.
`timescale 1ns/1ps
module tb_uart_rx;
    import uart_types_pkg::*;

    localparam int OS   = 16;
    localparam int TD   = 4;
    localparam int BITC = OS * TD;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       baud_tick_16x = 1'b0;
    logic       rx_i = 1'b1;
    logic       rx_en = 1'b1;
    lcr_t       lcr = '0;
    logic [7:0] rx_data;
    logic       rx_pe, rx_fe, rx_bi, rx_valid, rx_busy;

    uart_rx #(.OVERSAMPLE(OS), .SYNC_STAGES(2)) dut (
        .clk           (clk),
        .rst           (rst),
        .baud_tick_16x (baud_tick_16x),
        .rx_i          (rx_i),
        .rx_en         (rx_en),
        .lcr           (lcr),
        .rx_data       (rx_data),
        .rx_pe         (rx_pe),
        .rx_fe         (rx_fe),
        .rx_bi         (rx_bi),
        .rx_valid      (rx_valid),
        .rx_busy       (rx_busy)
    );

    always #5 clk = ~clk;

    int tdiv = 0;
    always @(posedge clk) begin
        #1;
        tdiv = (tdiv + 1) % TD;
        baud_tick_16x = (tdiv == 0);
    end

    int       checks = 0;
    int       errors = 0;
    int       n_valid = 0;
    rx_word_t exp_q[$];
    rx_word_t held = '0;
    rx_word_t last_got = '0;
    rx_word_t got;
    rx_word_t exp_w;
    logic     rst_at_edge = 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    function automatic logic good_parity(input lcr_t c, input logic [7:0] m);
        if (c.stick_parity)
            return !c.eps;
        if (c.eps)
            return ($countones(m) % 2) == 1;
        return ($countones(m) % 2) == 0;
    endfunction

    // What the receiver must report for a frame as it appeared on the line.
    function automatic rx_word_t model(input lcr_t c, input logic [7:0] m,
                                       input logic par, input logic stop);
        rx_word_t w;
        w.data = m;
        w.pe   = c.pen && (par != good_parity(c, m));
        w.fe   = !stop;
        w.bi   = (m == 8'h00) && (!c.pen || !par) && !stop;
        return w;
    endfunction

    always @(posedge clk) rst_at_edge <= rst;

    always @(negedge clk) begin
        got = '{bi: rx_bi, fe: rx_fe, pe: rx_pe, data: rx_data};
        if (rst_at_edge) begin
            held = '0;
            chk("reset_word", 32'(got), 32'h0);
            chk("reset_valid", 32'(rx_valid), 32'h0);
            chk("reset_busy", 32'(rx_busy), 32'h0);
        end else if (rx_valid === 1'b1) begin
            n_valid++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_valid actual=%0h required=no_word t=%0t", got, $time);
            end else begin
                exp_w = exp_q.pop_front();
                chk("word", 32'(got), 32'(exp_w));
                held = exp_w;
                if (!exp_w.bi)
                    chk("busy_at_push", 32'(rx_busy), 32'h0);
            end
            last_got = got;
        end else begin
            chk("hold", 32'(got), 32'(held));
        end
    end

    task automatic waitc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input lcr_t cfg, input logic [7:0] d, input bit flip,
                              input bit good_stop, input int abort_at, input bit abort_rst);
        int         nb;
        int         v0;
        logic [7:0] m;
        logic       par;
        nb  = UART_MIN_BITS + int'(cfg.wls);
        m   = d & 8'((1 << nb) - 1);
        par = good_parity(cfg, m) ^ flip;
        v0  = n_valid;
        lcr = cfg;
        rx_i = 1'b0;
        waitc(BITC / 2);
        lcr = lcr_t'(8'($urandom));
        waitc(BITC / 2);
        for (int i = 0; i < nb; i++) begin
            if (i == abort_at) begin
                rx_i = 1'b1;
                if (abort_rst) begin
                    rst = 1'b1; waitc(2); rst = 1'b0;
                end else begin
                    rx_en = 1'b0; waitc(3); rx_en = 1'b1;
                end
                waitc(BITC * 12);
                chk("abort_no_word", 32'(n_valid), 32'(v0));
                chk("abort_idle", 32'(rx_busy), 32'h0);
                return;
            end
            rx_i = m[i];
            waitc(BITC);
        end
        if (cfg.pen) begin
            rx_i = par;
            waitc(BITC);
        end
        exp_q.push_back(model(cfg, m, par, good_stop));
        if (good_stop) begin
            rx_i = 1'b1;
            waitc(BITC);
        end else begin
            rx_i = 1'b0;
            waitc(10 * TD);
            rx_i = 1'b1;
            waitc(2 * BITC - 10 * TD);
        end
        chk("word_by_stop_end", 32'(exp_q.size()), 32'h0);
        chk("idle_after_stop", 32'(rx_busy), 32'h0);
        chk("one_word_per_frame", 32'(n_valid), 32'(v0 + 1));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    lcr_t cfg;
    int   v0;
    int   busy_cnt;

    initial begin
        waitc(5);
        rst = 1'b0;
        waitc(BITC);

        // 8N1 0xA5
        cfg = '0; cfg.wls = 2'd3;
        send_frame(cfg, 8'hA5, 1'b0, 1'b1, -1, 1'b0);
        chk("lit_8n1_a5", 32'(last_got), 32'h0A5);

        // 7E1 0x35 with wrong parity
        cfg = '0; cfg.wls = 2'd2; cfg.pen = 1'b1; cfg.eps = 1'b1;
        send_frame(cfg, 8'h35, 1'b1, 1'b1, -1, 1'b0);
        chk("lit_7e1_pe", 32'(last_got), 32'h135);

        // 5-bit stick parity (expects 1)
        cfg = '0; cfg.pen = 1'b1; cfg.stick_parity = 1'b1;
        send_frame(cfg, 8'h1F, 1'b0, 1'b1, -1, 1'b0);
        chk("lit_stick_ok", 32'(last_got), 32'h01F);
        send_frame(cfg, 8'h1F, 1'b1, 1'b1, -1, 1'b0);
        chk("lit_stick_pe", 32'(last_got), 32'h11F);

        // Framing error on non-zero data: short low stop, resync start is false
        cfg = '0; cfg.wls = 2'd3;
        send_frame(cfg, 8'h55, 1'b0, 1'b0, -1, 1'b0);
        chk("lit_fe", 32'(last_got), 32'h255);

        // False start: low for 5 ticks
        v0 = n_valid;
        busy_cnt = 0;
        rx_i = 1'b0;
        for (int c = 0; c < 5 * TD + 40; c++) begin
            if (c == 5 * TD)
                rx_i = 1'b1;
            waitc(1);
            if (rx_busy === 1'b1)
                busy_cnt++;
        end
        chk("false_start_busy_len", 32'(busy_cnt >= 7 * TD && busy_cnt <= 9 * TD + 2), 32'h1);
        chk("false_start_no_word", 32'(n_valid), 32'(v0));
        chk("false_start_idle", 32'(rx_busy), 32'h0);

        // Break: low for three 8N1 frame times
        cfg = '0; cfg.wls = 2'd3;
        lcr = cfg;
        v0 = n_valid;
        exp_q.push_back(model(cfg, 8'h00, 1'b0, 1'b0));
        rx_i = 1'b0;
        waitc(30 * BITC);
        chk("break_one_word", 32'(n_valid), 32'(v0 + 1));
        chk("break_busy_held", 32'(rx_busy), 32'h1);
        rx_i = 1'b1;
        waitc(2 * BITC);
        chk("break_idle", 32'(rx_busy), 32'h0);
        chk("break_no_more", 32'(n_valid), 32'(v0 + 1));
        chk("lit_break", 32'(last_got), 32'h600);

        // Aborts mid-DATA, then a clean frame
        send_frame(cfg, 8'hC3, 1'b0, 1'b1, 3, 1'b1);
        send_frame(cfg, 8'h3C, 1'b0, 1'b1, -1, 1'b0);
        chk("lit_after_rst", 32'(last_got), 32'h03C);
        send_frame(cfg, 8'hC3, 1'b0, 1'b1, 4, 1'b0);
        send_frame(cfg, 8'h3C, 1'b0, 1'b1, -1, 1'b0);
        chk("lit_after_en", 32'(last_got), 32'h03C);

        // Random frames, back-to-back or with random gaps
        for (int n = 0; n < 30; n++) begin
            cfg = lcr_t'(8'($urandom));
            send_frame(cfg, 8'($urandom), ($urandom_range(0, 3) == 0), 1'b1, -1, 1'b0);
            waitc($urandom_range(0, 20) * TD);
        end

        waitc(BITC);
        chk("queue_empty", 32'(exp_q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
